// File: rtl/instr_decode_ctrl_if.sv
// Instruction handshake, register-file access and ALU-side bus of the decode/control FSM.
// The controller connects through the slave modport; the instruction source and the
// register file sit on the master side.
interface instr_decode_ctrl_if #(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand_1;
  logic [IMM_W-1:0]  operand_2;
  logic [DATA_W-1:0] data_out;
  logic              mem_ack;
  logic              cs;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [OPC_W-1:0]  alu_operation;
  logic [DATA_W-1:0] alu_opr1;
  logic [IMM_W-1:0]  alu_opr2;
  logic              alu_start;
  logic              wb;
  logic              halted;
  logic              err;
  logic              illegal;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    output instr_valid, opcode, operand_1, operand_2, data_out, mem_ack,
    input  instr_ready, cs, rw, address, alu_operation, alu_opr1, alu_opr2,
           alu_start, wb, halted, err, illegal, instr_cnt
  );

  modport slave (
    input  instr_valid, opcode, operand_1, operand_2, data_out, mem_ack,
    output instr_ready, cs, rw, address, alu_operation, alu_opr1, alu_opr2,
           alu_start, wb, halted, err, illegal, instr_cnt
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle instruction decode/control FSM: accept, decode, register read with ack
// timeout, ALU start, write-back, HALT/NOP handling and a retired-instruction counter.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (out-of-range opcodes trap instead of
// executing; illegal becomes a sticky flag).
module instr_decode_ctrl #(
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned IMM_W    = 8,
  parameter int unsigned NUM_OPS  = 12,
  parameter int unsigned NOP_OPC  = 0,
  parameter int unsigned HALT_OPC = 15,
  parameter int unsigned ACK_TMO  = 15,
  parameter int unsigned CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  instr_decode_ctrl_if.slave bus
);
  localparam int unsigned TMO_W = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP      = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              cs_q, cs_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [DATA_W-1:0] opr1_q, opr1_d;
  logic [IMM_W-1:0]  opr2_q, opr2_d;
  logic              start_q, start_d;
  logic              wb_q, wb_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  wait_q, wait_d;
  logic              op_oor_c;
  logic              tmo_c;

  // Latched opcode outside the legal range, and last allowed cycle of an ack wait.
  assign op_oor_c = (32'(op_q) >= NUM_OPS);
  assign tmo_c    = (wait_q == TMO_W'(ACK_TMO - 1));

`ifndef DECODE_ILLEGAL_TRAP_EN
  logic trap_unused;
  assign trap_unused = op_oor_c;
`endif

  // Next-state and next-output logic; every output is a register updated here.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    cs_d      = cs_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    op_d      = op_q;
    opr1_d    = opr1_q;
    opr2_d    = opr2_q;
    start_d   = 1'b0;
    wb_d      = wb_q;
    halted_d  = halted_q;
    err_d     = 1'b0;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && ready_q) begin
          op_d    = bus.opcode;
          addr_d  = bus.operand_1;
          opr2_d  = bus.operand_2;
          ready_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OPC_W'(HALT_OPC)) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (op_q == OPC_W'(NOP_OPC)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          ready_d = 1'b1;
          state_d = S_IDLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
        end else if (op_oor_c) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
`endif
        end else begin
          cs_d    = 1'b1;
          rw_d    = 1'b1;
          wait_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.mem_ack) begin
          opr1_d  = bus.data_out;
          cs_d    = 1'b0;
          start_d = 1'b1;
          state_d = S_EXECUTE;
        end else if (tmo_c) begin
          err_d   = 1'b1;
          cs_d    = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_EXECUTE: begin
        cs_d    = 1'b1;
        rw_d    = 1'b0;
        wb_d    = 1'b1;
        wait_d  = '0;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (bus.mem_ack) begin
          cs_d    = 1'b0;
          wb_d    = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_c) begin
          err_d   = 1'b1;
          cs_d    = 1'b0;
          wb_d    = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        cs_d    = 1'b0;
        wb_d    = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      cs_q      <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      op_q      <= '0;
      opr1_q    <= '0;
      opr2_q    <= '0;
      start_q   <= 1'b0;
      wb_q      <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cs_q      <= cs_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      opr1_q    <= opr1_d;
      opr2_q    <= opr2_d;
      start_q   <= start_d;
      wb_q      <= wb_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.instr_ready   = ready_q;
  assign bus.cs            = cs_q;
  assign bus.rw            = rw_q;
  assign bus.address       = addr_q;
  assign bus.alu_operation = op_q;
  assign bus.alu_opr1      = opr1_q;
  assign bus.alu_opr2      = opr2_q;
  assign bus.alu_start     = start_q;
  assign bus.wb            = wb_q;
  assign bus.halted        = halted_q;
  assign bus.err           = err_q;
  assign bus.illegal       = illegal_q;
  assign bus.instr_cnt     = cnt_q;
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl: normal op, back-pressure, ack timeout,
// NOP/HALT decode, out-of-range opcode and asynchronous reset mid-access.
module tb_instr_decode_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   exp_cnt;
  bit   auto_ack;

  instr_decode_ctrl_if bus ();

  instr_decode_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the register file acks in the same cycle it sees cs when auto_ack is set.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.mem_ack = auto_ack && bus.cs;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [7:0] imm);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.operand_1   = a;
    bus.operand_2   = imm;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic run_to_idle(output int n, output bit s_start, output bit s_wb, output bit s_cs);
    n = 0; s_start = 1'b0; s_wb = 1'b0; s_cs = 1'b0;
    while (!bus.instr_ready && n < 40) begin
      tick();
      n++;
      if (bus.alu_start) s_start = 1'b1;
      if (bus.wb)        s_wb    = 1'b1;
      if (bus.cs)        s_cs    = 1'b1;
    end
    check("ready_back", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    int n;
    bit s_start, s_wb, s_cs, s_err;
    vectors = 0; miscompares = 0; exp_cnt = 0; auto_ack = 1'b1;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.opcode = '0; bus.operand_1 = '0; bus.operand_2 = '0;
    bus.data_out = '0; bus.mem_ack = 1'b0;
    #12;
    check("rst_ready",   32'(bus.instr_ready), 32'd1);
    check("rst_cs",      32'(bus.cs),          32'd0);
    check("rst_cnt",     32'(bus.instr_cnt),   32'd0);
    check("rst_halted",  32'(bus.halted),      32'd0);
    check("rst_illegal", 32'(bus.illegal),     32'd0);
    #11 rst_n = 1'b1;
    tick();

    // Normal op: ready returns 4 edges after the accepting edge (5 cycles from accept).
    bus.data_out = 16'h1234;
    issue(4'd3, 4'd5, 8'hA5);
    check("acc_ready",   32'(bus.instr_ready),   32'd0);
    check("acc_addr",    32'(bus.address),       32'd5);
    check("acc_op",      32'(bus.alu_operation), 32'd3);
    check("acc_opr2",    32'(bus.alu_opr2),      32'hA5);
    run_to_idle(n, s_start, s_wb, s_cs);
    exp_cnt++;
    check("norm_latency", 32'(n),               32'd4);
    check("norm_start",   32'(s_start),         32'd1);
    check("norm_wb",      32'(s_wb),            32'd1);
    check("norm_opr1",    32'(bus.alu_opr1),    32'h1234);
    check("norm_cnt",     32'(bus.instr_cnt),   32'(exp_cnt));
    check("norm_cs_off",  32'(bus.cs),          32'd0);

    // NOP: retired straight from decode, no register access.
    issue(4'd0, 4'd2, 8'h00);
    run_to_idle(n, s_start, s_wb, s_cs);
    exp_cnt++;
    check("nop_latency", 32'(n),             32'd1);
    check("nop_cs",      32'(s_cs),          32'd0);
    check("nop_cnt",     32'(bus.instr_cnt), 32'(exp_cnt));

    // Back-pressure: valid held, fields change while busy.
    bus.data_out = 16'hBEEF;
    bus.instr_valid = 1'b1; bus.opcode = 4'd4; bus.operand_1 = 4'd7; bus.operand_2 = 8'h3C;
    tick();
    bus.opcode = 4'd9; bus.operand_1 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_op_hold", 32'(bus.alu_operation), 32'd4);
    end
    tick();
    exp_cnt++;
    check("bp_ready", 32'(bus.instr_ready),   32'd1);
    check("bp_cnt",   32'(bus.instr_cnt),     32'(exp_cnt));
    check("bp_opr1",  32'(bus.alu_opr1),      32'hBEEF);
    tick();
    bus.instr_valid = 1'b0;
    check("bp_op2",   32'(bus.alu_operation), 32'd9);
    check("bp_addr2", 32'(bus.address),       32'd1);
    run_to_idle(n, s_start, s_wb, s_cs);
    exp_cnt++;
    check("bp_cnt2",  32'(bus.instr_cnt),     32'(exp_cnt));

    // Timeout in READ: err 15 edges after the READ-entry edge.
    auto_ack = 1'b0;
    issue(4'd5, 4'd3, 8'h00);
    tick();
    check("tmo_cs", 32'(bus.cs), 32'd1);
    n = 0; s_err = 1'b0;
    while (!s_err && n < 40) begin
      tick();
      n++;
      s_err = bus.err;
    end
    check("tmo_cycles", 32'(n),               32'd15);
    check("tmo_ready",  32'(bus.instr_ready), 32'd1);
    check("tmo_cs_off", 32'(bus.cs),          32'd0);
    check("tmo_cnt",    32'(bus.instr_cnt),   32'(exp_cnt));
    tick();
    check("tmo_pulse",  32'(bus.err),         32'd0);

    // Ack on the 15th READ cycle wins over the timeout.
    bus.data_out = 16'h5555;
    issue(4'd5, 4'd3, 8'h00);
    tick();
    s_err = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.err) s_err = 1'b1;
    end
    bus.mem_ack = 1'b1;
    tick();
    if (bus.err) s_err = 1'b1;
    check("ack15_err",   32'(s_err),         32'd0);
    check("ack15_start", 32'(bus.alu_start), 32'd1);
    check("ack15_opr1",  32'(bus.alu_opr1),  32'h5555);
    auto_ack = 1'b1;
    run_to_idle(n, s_start, s_wb, s_cs);
    exp_cnt++;
    check("ack15_cnt",   32'(bus.instr_cnt), 32'(exp_cnt));

    // Asynchronous reset in the middle of READ.
    auto_ack = 1'b0;
    issue(4'd2, 4'd1, 8'h00);
    tick();
    check("mid_cs", 32'(bus.cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs",    32'(bus.cs),          32'd0);
    check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
    check("mid_rst_cnt",   32'(bus.instr_cnt),   32'd0);
    exp_cnt = 0;
    #2 rst_n = 1'b1;
    auto_ack = 1'b1;
    tick();

    // Out-of-range opcode 13.
    issue(4'd13, 4'd6, 8'h11);
`ifdef DECODE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) tick();
    check("trap_illegal", 32'(bus.illegal),     32'd1);
    check("trap_ready",   32'(bus.instr_ready), 32'd0);
    check("trap_cs",      32'(bus.cs),          32'd0);
    check("trap_cnt",     32'(bus.instr_cnt),   32'(exp_cnt));
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("trap_clear",   32'(bus.illegal),     32'd0);
`else
    run_to_idle(n, s_start, s_wb, s_cs);
    exp_cnt++;
    check("op13_start",   32'(s_start),         32'd1);
    check("op13_cnt",     32'(bus.instr_cnt),   32'(exp_cnt));
    check("op13_illegal", 32'(bus.illegal),     32'd0);
`endif

    // HALT: sticks, later instructions ignored.
    issue(4'd15, 4'd0, 8'h00);
    tick();
    check("halt_halted", 32'(bus.halted),      32'd1);
    check("halt_ready",  32'(bus.instr_ready), 32'd0);
    bus.instr_valid = 1'b1; bus.opcode = 4'd3; bus.operand_1 = 4'd9;
    s_cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.cs) s_cs = 1'b1;
    end
    bus.instr_valid = 1'b0;
    check("halt_hold",   32'(bus.halted),        32'd1);
    check("halt_op",     32'(bus.alu_operation), 32'd15);
    check("halt_cs",     32'(s_cs),              32'd0);
    check("halt_cnt",    32'(bus.instr_cnt),     32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
